icache_line_fill_responder: RTL and testbench



---
 rtl/icache_line_fill_responder.sv | 176 +++++++++++++++++
 tb/tb_icache_line_fill_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_fill_responder
// Purpose  : Turns one I-cache line read into one bmem burst. The burst beats
//            are assembled into a 256-bit line and returned with a dfp_resp
//            pulse. Optional last-line buffer: ICACHE_FILL_LINE_BUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module icache_line_fill_responder #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  output logic [255:0]      dfp_rdata,
  output logic [31:0]       dfp_raddr,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int             LINE_W    = 256;
  localparam int             CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [31:0]    LINE_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  dfp_rdata_q, dfp_rdata_d;
  logic [31:0]        dfp_raddr_q, dfp_raddr_d;
  logic               dfp_resp_q, dfp_resp_d;
  logic [31:0]        bmem_addr_q, bmem_addr_d;
  logic               bmem_read_q, bmem_read_d;
  logic [31:0]        req_addr;

`ifdef ICACHE_FILL_LINE_BUF_EN
  logic [31:0]        buf_addr_q, buf_addr_d;
  logic [LINE_W-1:0]  buf_data_q, buf_data_d;
  logic               buf_valid_q, buf_valid_d;
`endif

  assign req_addr = dfp_addr & LINE_MASK;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    dfp_rdata_d = dfp_rdata_q;
    dfp_raddr_d = dfp_raddr_q;
    dfp_resp_d  = 1'b0;
    bmem_addr_d = bmem_addr_q;
    bmem_read_d = bmem_read_q;
`ifdef ICACHE_FILL_LINE_BUF_EN
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (dfp_read) begin
          addr_d = req_addr;
`ifdef ICACHE_FILL_LINE_BUF_EN
          if (buf_valid_q && (req_addr == buf_addr_q)) begin
            dfp_rdata_d = buf_data_q;
            dfp_raddr_d = buf_addr_q;
            dfp_resp_d  = 1'b1;
            state_d     = S_RESP;
          end else begin
            bmem_addr_d = req_addr;
            bmem_read_d = 1'b1;
            state_d     = S_REQ;
          end
`else
          bmem_addr_d = req_addr;
          bmem_read_d = 1'b1;
          state_d     = S_REQ;
`endif
        end
      end

      S_REQ: begin
        if (bmem_ready) begin
          bmem_read_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_FILL;
        end
      end

      S_FILL: begin
        // Beats tagged for another line are stale traffic and are dropped.
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            dfp_rdata_d = line_d;
            dfp_raddr_d = addr_q;
            dfp_resp_d  = 1'b1;
            state_d     = S_RESP;
`ifdef ICACHE_FILL_LINE_BUF_EN
            buf_addr_d  = addr_q;
            buf_data_d  = line_d;
            buf_valid_d = 1'b1;
`endif
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      dfp_rdata_q <= '0;
      dfp_raddr_q <= '0;
      dfp_resp_q  <= 1'b0;
      bmem_addr_q <= '0;
      bmem_read_q <= 1'b0;
`ifdef ICACHE_FILL_LINE_BUF_EN
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      dfp_rdata_q <= dfp_rdata_d;
      dfp_raddr_q <= dfp_raddr_d;
      dfp_resp_q  <= dfp_resp_d;
      bmem_addr_q <= bmem_addr_d;
      bmem_read_q <= bmem_read_d;
`ifdef ICACHE_FILL_LINE_BUF_EN
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
`endif
    end
  end

  assign dfp_rdata = dfp_rdata_q;
  assign dfp_raddr = dfp_raddr_q;
  assign dfp_resp  = dfp_resp_q;
  assign bmem_addr = bmem_addr_q;
  assign bmem_read = bmem_read_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_line_fill_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_line_fill_responder
// Purpose  : Directed, table-driven bench for icache_line_fill_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_line_fill_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  dfp_addr = '0;
  logic         dfp_read = 1'b0;
  logic [255:0] dfp_rdata;
  logic [31:0]  dfp_raddr;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_ready = 1'b0;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  icache_line_fill_responder #(.BEAT_W(64), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_rdata  (dfp_rdata),
    .dfp_raddr  (dfp_raddr),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  // Accepted bmem request handshakes.
  always @(posedge clk) begin
    if (!rst && bmem_read && bmem_ready) hs_cnt <= hs_cnt + 1;
  end

  typedef struct {
    logic [31:0]  addr;
    int           dly;
    int           gap;
    bit           stray;
    logic [63:0]  b0, b1, b2, b3;
    logic [31:0]  exp_raddr;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_beat(input int k, input vec_t v);
    bmem_rvalid = 1'b1;
    bmem_raddr  = v.exp_raddr;
    case (k)
      0:       bmem_rdata = v.b0;
      1:       bmem_rdata = v.b1;
      2:       bmem_rdata = v.b2;
      default: bmem_rdata = v.b3;
    endcase
  endtask

  // Full transaction; dfp_read held until dfp_resp is observed, then dropped.
  task automatic run_txn(input vec_t v);
    int hs0;
    hs0 = hs_cnt;
    dfp_addr = v.addr;
    dfp_read = 1'b1;
    tick();
    chk("issue_read", 256'(bmem_read), 256'(1'b1));
    chk("issue_addr", 256'(bmem_addr), 256'(v.exp_raddr));
    dfp_addr = 32'h0BAD_0000;
    for (int i = 0; i < v.dly; i++) begin
      tick();
      chk("req_hold", 256'({bmem_read, bmem_addr}), 256'({1'b1, v.exp_raddr}));
    end
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    chk("read_clr", 256'(bmem_read), 256'(1'b0));
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < v.gap; g++) begin
        if (v.stray && k == 2 && g == 0) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = 32'h0000_4000;
          bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        end else begin
          bmem_rvalid = 1'b0;
        end
        tick();
        bmem_rvalid = 1'b0;
        chk("no_early_resp", 256'(dfp_resp), 256'(1'b0));
      end
      drive_beat(k, v);
      tick();
      bmem_rvalid = 1'b0;
      if (k < 3) chk("no_early_resp", 256'(dfp_resp), 256'(1'b0));
    end
    chk("resp", 256'(dfp_resp), 256'(1'b1));
    chk("rdata", dfp_rdata, v.exp_line);
    chk("raddr", 256'(dfp_raddr), 256'(v.exp_raddr));
    chk("one_burst", 256'(hs_cnt - hs0), 256'(1));
    dfp_read = 1'b0;
    tick();
    chk("resp_pulse", 256'(dfp_resp), 256'(1'b0));
    chk("no_reissue", 256'(bmem_read), 256'(1'b0));
    chk("rdata_hold", dfp_rdata, v.exp_line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    vecs[0] = '{32'h0000_1234, 0, 0, 1'b0,
                64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
                32'h0000_1220,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{32'h0000_8ABC, 5, 2, 1'b0,
                64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                32'h0000_8AA0,
                {64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5,
                 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}};
    vecs[2] = '{32'hFFFF_FFFF, 1, 1, 1'b1,
                64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002,
                64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004,
                32'hFFFF_FFE0,
                {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001}};
    vecs[3] = '{32'h0000_001F, 0, 0, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                32'h0000_0000,
                {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF}};
    vecs[4] = '{32'h0000_2010, 0, 0, 1'b0,
                64'hCAFE_0000_0000_0000, 64'hCAFE_1111_1111_1111,
                64'hCAFE_2222_2222_2222, 64'hCAFE_3333_3333_3333,
                32'h0000_2000,
                {64'hCAFE_3333_3333_3333, 64'hCAFE_2222_2222_2222,
                 64'hCAFE_1111_1111_1111, 64'hCAFE_0000_0000_0000}};

    tick();
    tick();
    chk("rst_rdata", dfp_rdata, 256'(0));
    chk("rst_ctrl", 256'({dfp_raddr, dfp_resp, bmem_addr, bmem_read}), 256'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Held request: high through RESP, still high in IDLE -> second burst.
    hs0 = hs_cnt;
    dfp_addr = 32'h0000_1234;
    dfp_read = 1'b1;
    tick();
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_beat(k, vecs[0]);
      tick();
    end
    bmem_rvalid = 1'b0;
    chk("held_resp", 256'(dfp_resp), 256'(1'b1));
    tick();
    chk("held_no_issue_in_resp", 256'(bmem_read), 256'(1'b0));
    tick();
    chk("held_second_burst", 256'(bmem_read), 256'(1'b1));
    dfp_read = 1'b0;
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_beat(k, vecs[0]);
      tick();
    end
    bmem_rvalid = 1'b0;
    chk("held_resp2", 256'(dfp_resp), 256'(1'b1));
    chk("held_hs_count", 256'(hs_cnt - hs0), 256'(2));
    tick();

    // Async reset in FILL after two beats.
    dfp_addr = vecs[4].addr;
    dfp_read = 1'b1;
    tick();
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_beat(k, vecs[4]);
      tick();
    end
    bmem_rvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_rdata", dfp_rdata, 256'(0));
    chk("arst_ctrl", 256'({dfp_raddr, dfp_resp, bmem_addr, bmem_read}), 256'(0));
    dfp_read = 1'b0;
    tick();
    #2 rst = 1'b0;
    for (int k = 2; k < 4; k++) begin
      drive_beat(k, vecs[4]);
      tick();
      chk("late_beat_ignored", 256'({dfp_resp, bmem_read}), 256'(0));
    end
    bmem_rvalid = 1'b0;
    tick();
    chk("late_rdata", dfp_rdata, 256'(0));
    run_txn(vecs[4]);

`ifdef ICACHE_FILL_LINE_BUF_EN
    begin
      bit seen_resp;
      bit seen_read;
      hs0 = hs_cnt;
      seen_resp = 1'b0;
      seen_read = 1'b0;
      dfp_addr = vecs[4].addr;
      dfp_read = 1'b1;
      for (int i = 0; i < 4 && !seen_resp; i++) begin
        tick();
        if (bmem_read) seen_read = 1'b1;
        if (dfp_resp) begin
          seen_resp = 1'b1;
          chk("buf_rdata", dfp_rdata, vecs[4].exp_line);
          chk("buf_raddr", 256'(dfp_raddr), 256'(vecs[4].exp_raddr));
        end
      end
      dfp_read = 1'b0;
      chk("buf_resp_seen", 256'(seen_resp), 256'(1'b1));
      chk("buf_no_bmem", 256'({seen_read, 32'(hs_cnt - hs0)}), 256'(0));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dfp_read = 1'b1;
      tick();
      dfp_read = 1'b0;
      chk("buf_cleared_burst", 256'(bmem_read), 256'(1'b1));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
